cond_logic: RTL and testbench

Conditional-execution unit of the single-cycle ARM controller. Holds the NZCV status flags and evaluates the 4-bit instruction condition field against them. Gates the decoder's write/branch requests (pcs, reg_w, mem_w) into the final pc_src, reg_write and mem_write strobes. Sits between the main decoder and the datapath.

---
 rtl/cond_logic.sv | 91 +++++++++
 tb/tb_cond_logic.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cond_logic.sv
// Conditional-execution unit: NZCV flag register, ARM condition evaluation and
// write/branch strobe gating. Optional macro COND_LOGIC_NV_NEVER_EN makes cond=1111 "never".
module cond_logic #(
  parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pcs,
  input  logic       reg_w,
  input  logic       mem_w,
  input  logic [1:0] flag_w,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  output logic       pc_src,
  output logic       reg_write,
  output logic       mem_write
);

`ifdef COND_LOGIC_NV_NEVER_EN
  localparam logic NV_PASS = 1'b0;
`else
  localparam logic NV_PASS = 1'b1;
`endif

  logic [3:0] flags_q;
  logic [3:0] flags_d;
  logic       cond_ex_s;

  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n_s;
    logic z_s;
    logic c_s;
    logic v_s;
    logic r_s;
    n_s = f[3];
    z_s = f[2];
    c_s = f[1];
    v_s = f[0];
    case (c)
      4'b0000: r_s = z_s;
      4'b0001: r_s = ~z_s;
      4'b0010: r_s = c_s;
      4'b0011: r_s = ~c_s;
      4'b0100: r_s = n_s;
      4'b0101: r_s = ~n_s;
      4'b0110: r_s = v_s;
      4'b0111: r_s = ~v_s;
      4'b1000: r_s = c_s & ~z_s;
      4'b1001: r_s = ~c_s | z_s;
      4'b1010: r_s = (n_s == v_s);
      4'b1011: r_s = (n_s != v_s);
      4'b1100: r_s = ~z_s & (n_s == v_s);
      4'b1101: r_s = z_s | (n_s != v_s);
      4'b1110: r_s = 1'b1;
      default: r_s = NV_PASS;
    endcase
    return r_s;
  endfunction

  // Condition always sees the flags stored before the current edge.
  assign cond_ex_s = cond_eval(cond, flags_q);

  assign pc_src    = pcs   & cond_ex_s;
  assign reg_write = reg_w & cond_ex_s;
  assign mem_write = mem_w & cond_ex_s;

  // Next-state flags: N,Z and C,V halves update independently.
  always_comb begin
    flags_d = flags_q;
    if (flag_w[1] && cond_ex_s) begin
      flags_d[3:2] = alu_flags[3:2];
    end else begin
      flags_d[3:2] = flags_q[3:2];
    end
    if (flag_w[0] && cond_ex_s) begin
      flags_d[1:0] = alu_flags[1:0];
    end else begin
      flags_d[1:0] = flags_q[1:0];
    end
  end

  // Flag register with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q <= FLAGS_RESET;
    end else begin
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_cond_logic.sv
// Directed self-checking bench for cond_logic (default build, FLAGS_RESET = 0).
module tb_cond_logic;

  logic       clk;
  logic       reset_n;
  logic       pcs;
  logic       reg_w;
  logic       mem_w;
  logic [1:0] flag_w;
  logic [3:0] cond;
  logic [3:0] alu_flags;
  logic       pc_src;
  logic       reg_write;
  logic       mem_write;

  int total_cnt;
  int bad_cnt;

  cond_logic #(.FLAGS_RESET(4'b0000)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pcs       (pcs),
    .reg_w     (reg_w),
    .mem_w     (mem_w),
    .flag_w    (flag_w),
    .cond      (cond),
    .alu_flags (alu_flags),
    .pc_src    (pc_src),
    .reg_write (reg_write),
    .mem_write (mem_write)
  );

  // 400-unit period: outputs are checked 100 units after each rising edge.
  initial clk = 1'b0;
  always #200 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    total_cnt = total_cnt + 1;
    if (obs !== exp) begin
      bad_cnt = bad_cnt + 1;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #100;
  endtask

  // Load F through an AL instruction with both flag halves enabled.
  task automatic load_flags(input logic [3:0] f);
    cond      = 4'b1110;
    flag_w    = 2'b11;
    alu_flags = f;
    edge_step();
    flag_w    = 2'b00;
    alu_flags = 4'b0000;
  endtask

  // Probe one condition through reg_write.
  task automatic probe(input string tag, input logic [3:0] c, input logic exp);
    cond  = c;
    reg_w = 1'b1;
    #5;
    check(tag, reg_write, exp);
    reg_w = 1'b0;
    #5;
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    reset_n   = 1'b0;
    pcs       = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    flag_w    = 2'b00;
    cond      = 4'b1110;
    alu_flags = 4'b0000;
    #5;
    check("rst_pc_src", pc_src, 1'b0);
    check("rst_reg_write", reg_write, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    pcs = 1'b1;
    #5;
    check("rst_pc_follows", pc_src, 1'b1);
    pcs = 1'b0;
    #40;
    reset_n = 1'b1;

    // AL strobes
    edge_step();
    pcs = 1'b1;
    edge_step();
    check("al_pc_src", pc_src, 1'b1);
    reg_w = 1'b1;
    edge_step();
    check("al_reg_write", reg_write, 1'b1);
    mem_w = 1'b1;
    edge_step();
    check("al_mem_write", mem_write, 1'b1);
    pcs   = 1'b0;
    reg_w = 1'b0;
    mem_w = 1'b0;
    #5;
    check("al_pc_src_off", pc_src, 1'b0);

    // EQ before and after setting Z
    probe("eq_reset", 4'b0000, 1'b0);
    load_flags(4'b0100);
    probe("eq_z_set", 4'b0000, 1'b1);
    probe("ne_z_set", 4'b0001, 1'b0);

    // Split update: only C,V half written
    load_flags(4'b0000);
    probe("eq_cleared", 4'b0000, 1'b0);
    cond      = 4'b1110;
    flag_w    = 2'b01;
    alu_flags = 4'b1110;
    edge_step();
    flag_w    = 2'b00;
    probe("split_cs", 4'b0010, 1'b1);
    probe("split_mi", 4'b0100, 1'b0);
    probe("split_eq", 4'b0000, 1'b0);
    probe("split_cc", 4'b0011, 1'b0);
    probe("split_hi", 4'b1000, 1'b1);

    // Failed condition blocks flag writes
    load_flags(4'b0000);
    cond      = 4'b0000;
    flag_w    = 2'b11;
    alu_flags = 4'b0100;
    edge_step();
    flag_w    = 2'b00;
    probe("blocked_eq", 4'b0000, 1'b0);
    probe("blocked_ne", 4'b0001, 1'b1);

    // Signed conditions with N=1, V=1
    load_flags(4'b1001);
    probe("sgn_ge", 4'b1010, 1'b1);
    probe("sgn_gt", 4'b1100, 1'b1);
    probe("sgn_lt", 4'b1011, 1'b0);
    probe("sgn_le", 4'b1101, 1'b0);
    probe("sgn_hi", 4'b1000, 1'b0);
    probe("sgn_ls", 4'b1001, 1'b1);
    probe("sgn_vs", 4'b0110, 1'b1);
    probe("sgn_vc", 4'b0111, 1'b0);
    probe("sgn_pl", 4'b0101, 1'b0);
    cond  = 4'b1010;
    mem_w = 1'b1;
    #5;
    check("sgn_ge_mem_write", mem_write, 1'b1);
    mem_w = 1'b0;
    cond  = 4'b1011;
    pcs   = 1'b1;
    #5;
    check("sgn_lt_pc_src", pc_src, 1'b0);
    pcs = 1'b0;

    // Asynchronous reset mid-cycle
    load_flags(4'b1111);
    probe("all_eq", 4'b0000, 1'b1);
    cond = 4'b0110;
    pcs  = 1'b1;
    #5;
    check("all_vs_pc_src", pc_src, 1'b1);
    #45;
    reset_n = 1'b0;
    #5;
    check("async_vs_pc_src", pc_src, 1'b0);
    pcs = 1'b0;
    probe("async_eq", 4'b0000, 1'b0);
    probe("async_nv_default", 4'b1111, 1'b1);
    reset_n = 1'b1;
    edge_step();
    probe("post_rst_eq", 4'b0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
